tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4_pkg.sv | 23 ++
 rtl/tdm_demux4_slot_ctr.sv | 25 ++
 rtl/tdm_demux4.sv | 132 +++++++++++++
 tb/tb_tdm_demux4.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-slot TDM receive demultiplexer.
package tdm_demux4_pkg;

    // Number of slots per frame and the width of a slot index.
    localparam int NSLOTS = 4;
    localparam int SLOT_W = 2;

    // Index of the slot that completes a frame.
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOTS - 1);
    localparam logic [SLOT_W-1:0] FIRST_SLOT = '0;

    // Frame alignment state: HUNT waits for a frame_sync beat, LOCKED tracks slots.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Next slot index with wrap-around after the last slot.
    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        return (s == LAST_SLOT) ? FIRST_SLOT : s + SLOT_W'(1);
    endfunction

endpackage

// File: rtl/tdm_demux4_slot_ctr.sv
// Two-bit wrapping slot counter with clear and load-to-1 controls.
module tdm_slot_ctr
    import tdm_demux4_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              load_one,
    input  logic              advance,
    output logic [SLOT_W-1:0] slot
);

    // Clear wins over load, load wins over advance; otherwise the count holds.
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            slot <= FIRST_SLOT;
        end else if (load_one) begin
            slot <= SLOT_W'(1);
        end else if (advance) begin
            slot <= slot_inc(slot);
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of a 4:1 TDM mux: aligns on frame_sync, collects four slots
// into shadow registers and presents a complete frame on y0..y3 at once.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [W-1:0]      y0,
    output logic [W-1:0]      y1,
    output logic [W-1:0]      y2,
    output logic [W-1:0]      y3,
    output logic              frame_valid,
    output logic              sync_err,
    output logic [SLOT_W-1:0] slot,
    output logic              locked
);

    state_t              state;
    state_t              state_next;

    logic                ctr_load;
    logic                ctr_adv;
    logic                shadow_we;
    logic [SLOT_W-1:0]   shadow_idx;
    logic                frame_done;
    logic                sync_slip;

    logic [W-1:0]        shadow [NSLOTS];

    // Slot index of the next accepted beat.
    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .clear    (rst),
        .load_one (ctr_load),
        .advance  (ctr_adv),
        .slot     (slot)
    );

    assign locked = (state == LOCKED);

    // Next-state and per-beat control decode.
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        ctr_load   = 1'b0;
        ctr_adv    = 1'b0;
        shadow_we  = 1'b0;
        shadow_idx = slot;
        frame_done = 1'b0;
        sync_slip  = 1'b0;

        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    // Only a sync beat starts a frame; everything else is dropped.
                    if (frame_sync) begin
                        state_next = LOCKED;
                        ctr_load   = 1'b1;
                        shadow_we  = 1'b1;
                        shadow_idx = FIRST_SLOT;
                    end
                end
                LOCKED: begin
                    shadow_we = 1'b1;
                    if (frame_sync && slot != FIRST_SLOT) begin
                        // Sync arrived mid-frame: drop the partial frame and
                        // restart alignment with this beat as slot 0.
                        sync_slip  = 1'b1;
                        ctr_load   = 1'b1;
                        shadow_idx = FIRST_SLOT;
                    end else begin
                        ctr_adv    = 1'b1;
                        frame_done = (slot == LAST_SLOT);
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    // Alignment state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Shadow registers collecting the frame under construction.
    // NOTE: the shadow array is a small register file, not a RAM, so it is
    // cleared on reset along with everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOTS; i++) begin
                shadow[i] <= '0;
            end
        end else if (shadow_we) begin
            shadow[shadow_idx] <= din;
        end
    end

    // Output registers: a whole frame is published at once on the last slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            sync_err    <= sync_slip;
            if (frame_done) begin
                y0 <= shadow[0];
                y1 <= shadow[1];
                y2 <= shadow[2];
                y3 <= din;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (W=4).
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] y0, y1, y2, y3;
    logic         frame_valid;
    logic         sync_err;
    logic [1:0]   slot;
    logic         locked;

    int errors = 0;
    int checks = 0;

    tdm_demux4 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .slot        (slot),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ys();
        return {y0, y1, y2, y3};
    endfunction

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat followed by deasserted din_valid.
    task automatic beat(input logic [W-1:0] d, input logic fs);
        din        = d;
        frame_sync = fs;
        din_valid  = 1'b1;
        tick();
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;

        // Reset state.
        do_reset();
        check("rst_y",      32'(ys()), 32'h0000);
        check("rst_slot",   32'(slot), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_fv",     32'(frame_valid), 0);
        check("rst_se",     32'(sync_err), 0);

        // Basic frame 0,1,0,1 with sync on the first beat.
        beat(4'h0, 1'b1);
        check("f1_locked", 32'(locked), 1);
        check("f1_slot1",  32'(slot), 1);
        beat(4'h1, 1'b0);
        beat(4'h0, 1'b0);
        check("f1_fv_early", 32'(frame_valid), 0);
        check("f1_y_hold",   32'(ys()), 32'h0000);
        beat(4'h1, 1'b0);
        check("f1_fv",    32'(frame_valid), 1);
        check("f1_y",     32'(ys()), 32'h0101);
        check("f1_slot0", 32'(slot), 0);
        tick();
        check("f1_fv_pulse", 32'(frame_valid), 0);

        // Unsynced beats in HUNT are ignored, then a synced frame 1,0,0,0.
        do_reset();
        beat(4'h1, 1'b0);
        beat(4'h1, 1'b0);
        check("hunt_slot",   32'(slot), 0);
        check("hunt_locked", 32'(locked), 0);
        beat(4'h1, 1'b1);
        beat(4'h0, 1'b0);
        beat(4'h0, 1'b0);
        beat(4'h0, 1'b0);
        check("f2_fv", 32'(frame_valid), 1);
        check("f2_y",  32'(ys()), 32'h1000);

        // Frame 1,0,1,0 with a two-cycle gap after beat 2.
        beat(4'h1, 1'b1);
        beat(4'h0, 1'b0);
        tick();
        check("gap_slot_a", 32'(slot), 2);
        tick();
        check("gap_slot_b", 32'(slot), 2);
        check("gap_y_hold", 32'(ys()), 32'h1000);
        beat(4'h1, 1'b0);
        beat(4'h0, 1'b0);
        check("f3_fv", 32'(frame_valid), 1);
        check("f3_y",  32'(ys()), 32'h1010);

        // Sync slip at slot 2, then frame 0,0,1,1 restarting on the slip beat.
        beat(4'h7, 1'b1);
        beat(4'h7, 1'b0);
        check("slip_slot2", 32'(slot), 2);
        beat(4'h0, 1'b1);
        check("slip_se",     32'(sync_err), 1);
        check("slip_fv",     32'(frame_valid), 0);
        check("slip_slot",   32'(slot), 1);
        check("slip_locked", 32'(locked), 1);
        check("slip_y_hold", 32'(ys()), 32'h1010);
        beat(4'h0, 1'b0);
        check("slip_se_pulse", 32'(sync_err), 0);
        beat(4'h1, 1'b0);
        beat(4'h1, 1'b0);
        check("f4_fv", 32'(frame_valid), 1);
        check("f4_se", 32'(sync_err), 0);
        check("f4_y",  32'(ys()), 32'h0011);

        // Three back-to-back frames, values 0x0..0xB, din_valid held high.
        din_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din        = 4'(i);
            frame_sync = (i % 4 == 0);
            tick();
            check($sformatf("b2b_fv_%0d", i), 32'(frame_valid), 32'((i % 4) == 3));
            if (i % 4 == 3) begin
                check($sformatf("b2b_y3_%0d", i), 32'(y3), 32'(i));
                check($sformatf("b2b_y0_%0d", i), 32'(y0), 32'(i - 3));
            end
        end
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        check("b2b_y_last", 32'(ys()), 32'h89AB);

        // Reset at slot 2 with a beat presented in the same cycle.
        beat(4'h5, 1'b1);
        beat(4'h6, 1'b0);
        check("rst2_slot_pre", 32'(slot), 2);
        rst        = 1'b1;
        din_valid  = 1'b1;
        din        = 4'hF;
        tick();
        rst        = 1'b0;
        din_valid  = 1'b0;
        check("rst2_y",      32'(ys()), 32'h0000);
        check("rst2_locked", 32'(locked), 0);
        check("rst2_slot",   32'(slot), 0);
        check("rst2_fv",     32'(frame_valid), 0);
        for (int i = 0; i < 4; i++) begin
            beat(4'(i + 1), 1'b0);
            check($sformatf("rst2_nosync_fv_%0d", i), 32'(frame_valid), 0);
        end
        check("rst2_hunt_slot",   32'(slot), 0);
        check("rst2_hunt_locked", 32'(locked), 0);
        check("rst2_hunt_y",      32'(ys()), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
